serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial N-bit adder built around a single full-adder cell (a+b+cin -> {cout,sum}) plus a registered carry.
- Loads two WIDTH-bit operands on a start pulse and feeds them LSB-first through the cell, one bit per clock.
- Collects sum bits in a result shift register and presents the full sum and carry-out with a done pulse.
- Sits directly downstream of operand sources and wraps the 1-bit adder cell as its per-cycle datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on accepted start
- op_b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout updated
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held until next completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0; operand, result and carry registers and bit counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge captures op_a, op_b and cin (into the carry register), clears the counter and goes to SHIFT.
  - busy rises at that edge.
- SHIFT:
  - Each edge computes bit = a[0]^b[0]^c and c' = majority(a[0],b[0],c).
  - bit shifts into the result register from the MSB side; operand registers shift right; counter increments.
  - On the edge processing counter==WIDTH-1: sum<=final result, cout<=c', done<=1, busy<=0, state->DONE.
- DONE: one cycle only; done returns to 0 at the next edge and state->IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the edge that accepted start. Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored: no requeue, operands not recaptured. Operand changes after acceptance have no effect.
- sum/cout change only at completion and are never partially updated mid-operation.
- Counter width is clog2(WIDTH)+1; no wrap inside an operation.
- Reset mid-operation aborts immediately: no done pulse, outputs cleared to 0, next start behaves as from power-up.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with start.
  - When sub=1, op_b is stored inverted, the carry register initialises to 1 and cin is ignored, giving sum = op_a - op_b mod 2^WIDTH.
  - cout=1 means no borrow.
  - sub=0 behaves exactly as plain addition.
- Undefined: no sub port; add only; logic is absent from the netlist.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0, start 1 cycle -> busy high 8 cycles, done pulse 1 cycle, sum=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Accept 0x12+0x34, pulse start with 0xAA+0xAA at cycles 3 and 8 (relative to the accept edge) -> single done, sum=0x46, cout=0. Previous sum is held unchanged until that done.
- rst_n low after 4 processed bits of 0x0F+0x01 -> immediately busy=0, sum=0, cout=0, no done. Then 0x0F+0x01 -> sum=0x10, cout=0.
- Two back-to-back starts, the second asserted in the cycle done is high -> the second is ignored. Reasserted in IDLE it is accepted, and its done comes exactly WIDTH+2 cycles after the first done.
- With SERIAL_ADD_SUB_EN, sub=1, op_a=0x10, op_b=0x01 -> sum=0x0F, cout=1. With op_a=0x01, op_b=0x02 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the sub port).

module serial_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             c_q, c_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] shifted_res;

   serial_fa u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (c_q),
      .s  (fa_sum),
      .co (fa_cout)
   );

   // Only WIDTH-1 collected bits need storage; the last bit joins them at completion.
   assign shifted_res = {fa_sum, res_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = op_a;
`ifdef SERIAL_ADD_SUB_EN
               b_d     = sub ? ~op_b : op_b;
               c_d     = sub ? 1'b1 : cin;
`else
               b_d     = op_b;
               c_d     = cin;
`endif
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            res_d = shifted_res[WIDTH-1:1];
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = shifted_res;
               cout_d  = fa_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, corner sequences and random ops vs an arithmetic model.
// Define SERIAL_ADD_SUB_EN for both files to exercise subtract mode as well.

module tb_serial_adder_ctrl;
   localparam int W      = 8;
   localparam int BUDGET = 40;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a, op_b;
   logic         cin;
   logic         sub;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] prev_sum;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain modular arithmetic, subtraction as a + ~b + 1.
   task automatic model(input logic [W-1:0] a, b, input logic c, s,
                        output logic [W-1:0] es, output logic ec);
      logic [W-1:0] bb;
      logic [W:0]   total;
      bb    = s ? ~b : b;
      total = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
      es    = total[W-1:0];
      ec    = total[W];
   endtask

   // Called at posedge+1 with the DUT in IDLE; returns one cycle after the done pulse.
   task automatic do_op(input logic [W-1:0] a, b, input logic c, s,
                        input logic [W-1:0] es, input logic ec);
      int lat, bcnt;
      op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0; bcnt = 0;
      while (!done && lat < BUDGET) begin
         if (busy) bcnt++;
         check("sum_held", {56'd0, sum}, {56'd0, prev_sum});
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(W));
      check("busy_cycles", 64'(bcnt), 64'(W));
      check("busy_at_done", {63'd0, busy}, 64'd0);
      check("sum", {56'd0, sum}, {56'd0, es});
      check("cout", {63'd0, cout}, {63'd0, ec});
      $display("[TB] op a=0x%02h b=0x%02h cin=%0d sub=%0d -> sum=0x%02h cout=%0d (exp 0x%02h/%0d) lat=%0d",
               a, b, c, s, sum, cout, es, ec, lat);
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      prev_sum = es;
   endtask

   initial begin
      logic [W-1:0] es, ra, rb;
      logic         ec, rc, rs;
      int           ndone, gap;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      prev_sum = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_sum",  {56'd0, sum},  64'd0);
      check("rst_cout", {63'd0, cout}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].s, vecs[i].co);

      // Starts during SHIFT and DONE must be ignored; sum held until the single done.
      op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op_a = 8'hAA; op_b = 8'hAA;
      ndone = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (done) ndone++;
         else if (ndone == 0) check("ign_sum_held", {56'd0, sum}, {56'd0, prev_sum});
         start = (k == 3 || k == 8);
      end
      start = 1'b0;
      check("ign_done_count", 64'(ndone), 64'd1);
      check("ign_sum", {56'd0, sum}, 64'h46);
      check("ign_cout", {63'd0, cout}, 64'd0);
      check("ign_idle", {63'd0, busy}, 64'd0);
      $display("[TB] ignored-start seq: sum=0x%02h cout=%0d dones=%0d", sum, cout, ndone);
      prev_sum = 8'h46;

      // Start held from the done cycle: ignored in DONE, accepted in IDLE.
      op_a = 8'h21; op_b = 8'h43; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      gap = 0;
      while (!done && gap < BUDGET) begin
         @(posedge clk); #1;
         gap++;
      end
      check("b2b_first_lat", 64'(gap), 64'(W));
      check("b2b_first_sum", {56'd0, sum}, 64'h64);
      op_a = 8'h77; op_b = 8'h11; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("b2b_ignored_in_done", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_accepted_in_idle", {63'd0, busy}, 64'd1);
      gap = 2;
      while (!done && gap < BUDGET) begin
         @(posedge clk); #1;
         gap++;
      end
      check("b2b_done_gap", 64'(gap), 64'(W + 2));
      check("b2b_second_sum", {56'd0, sum}, 64'h89);
      check("b2b_second_cout", {63'd0, cout}, 64'd0);
      $display("[TB] back-to-back: gap=%0d sum=0x%02h cout=%0d", gap, sum, cout);
      @(posedge clk); #1;

      // Reset after four processed bits aborts with no done.
      op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_sum",  {56'd0, sum},  64'd0);
      check("abort_cout", {63'd0, cout}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      prev_sum = '0;
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort_no_done", 64'(ndone), 64'd0);
      $display("[TB] reset abort: busy=%0d sum=0x%02h dones=%0d", busy, sum, ndone);
      do_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      do_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
      do_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif

      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         model(ra, rb, rc, rs, es, ec);
         do_op(ra, rb, rc, rs, es, ec);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
